// File: rtl/bitop_rr_arbiter_if.sv
// rtl/bitop_rr_arbiter_if.sv - request/operand/result bundle for the shared bitwise unit arbiter
interface bitop_rr_arbiter_if #(
    parameter int W = 4
);
    logic [2:0]   req;
    logic [1:0]   op0;
    logic [1:0]   op1;
    logic [1:0]   op2;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [0:W-1] a1;
    logic [0:W-1] b1;
    logic [2:1]   a2;
    logic [2:1]   b2;
    logic [2:0]   gnt;
    logic [W-1:0] res;
    logic [1:0]   res_id;
    logic         res_valid;
    logic         res_ready;

    modport master (
        output req, op0, op1, op2, a0, b0, a1, b1, a2, b2, res_ready,
        input  gnt, res, res_id, res_valid
    );

    modport slave (
        input  req, op0, op1, op2, a0, b0, a1, b1, a2, b2, res_ready,
        output gnt, res, res_id, res_valid
    );
endinterface

// File: rtl/bitop_rr_arbiter.sv
// rtl/bitop_rr_arbiter.sv - round-robin arbiter sharing one W-bit AND/OR/XOR/pass unit among three requesters
module bitop_rr_arbiter #(
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bitop_rr_arbiter_if.slave    bus
);
    logic         s1_v;
    logic [1:0]   s1_op;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic [1:0]   s1_id;
    logic [1:0]   ptr;

    logic         s2_free;
    logic         s1_accept;
    logic         grant;
    logic         found;
    logic [1:0]   o0, o1, o2;
    logic [1:0]   win_id;
    logic [1:0]   sel_op;
    logic [W-1:0] sel_a, sel_b;
    logic [W-1:0] a1_al, b1_al, a2_al, b2_al;

    function automatic logic [W-1:0] bitop(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return a;
        endcase
    endfunction

    assign s2_free   = !bus.res_valid || bus.res_ready;
    assign s1_accept = !s1_v || s2_free;

    // Search order starts one past the last winner, wrapping modulo 3.
    always_comb begin
        case (ptr)
            2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
        endcase
        found  = 1'b1;
        win_id = o0;
        if (bus.req[o0])      win_id = o0;
        else if (bus.req[o1]) win_id = o1;
        else if (bus.req[o2]) win_id = o2;
        else                  found  = 1'b0;
    end

    assign grant   = found && !rst && s1_accept;
    assign bus.gnt = grant ? (3'b001 << win_id) : 3'b000;

    // Requester 1 maps by position (a1[0] lands in the MSB); requester 2 is zero-extended.
    always_comb begin
        a1_al        = bus.a1;
        b1_al        = bus.b1;
        a2_al        = '0;
        b2_al        = '0;
        a2_al[1:0]   = bus.a2;
        b2_al[1:0]   = bus.b2;
        case (win_id)
            2'd1:    begin sel_op = bus.op1; sel_a = a1_al;  sel_b = b1_al;  end
            2'd2:    begin sel_op = bus.op2; sel_a = a2_al;  sel_b = b2_al;  end
            default: begin sel_op = bus.op0; sel_a = bus.a0; sel_b = bus.b0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v          <= 1'b0;
            s1_op         <= '0;
            s1_a          <= '0;
            s1_b          <= '0;
            s1_id         <= '0;
            ptr           <= 2'd2;
            bus.res_valid <= 1'b0;
            bus.res       <= '0;
            bus.res_id    <= '0;
        end else begin
            // With S1 empty and S2 free, a granted op goes straight into S2.
            if (s1_v && s2_free) begin
                bus.res       <= bitop(s1_op, s1_a, s1_b);
                bus.res_id    <= s1_id;
                bus.res_valid <= 1'b1;
            end else if (grant && s2_free) begin
                bus.res       <= bitop(sel_op, sel_a, sel_b);
                bus.res_id    <= win_id;
                bus.res_valid <= 1'b1;
            end else if (bus.res_valid && bus.res_ready) begin
                bus.res_valid <= 1'b0;
            end

            if (grant && (s1_v || !s2_free)) begin
                s1_v  <= 1'b1;
                s1_op <= sel_op;
                s1_a  <= sel_a;
                s1_b  <= sel_b;
                s1_id <= win_id;
            end else if (s1_v && s2_free) begin
                s1_v <= 1'b0;
            end

            if (grant) ptr <= win_id;
        end
    end
endmodule

// File: tb/tb_bitop_rr_arbiter.sv
// tb/tb_bitop_rr_arbiter.sv - self-checking bench for bitop_rr_arbiter
module tb_bitop_rr_arbiter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    bitop_rr_arbiter_if #(.W(W)) bus ();

    bitop_rr_arbiter #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: results outstanding form a FIFO of depth 2; head is what res must show.
    logic [1:0]   qid[$];
    logic [W-1:0] qres[$];
    int           mptr = 2;
    bit           known = 0;

    function automatic logic [W-1:0] m_f(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) begin
            case (op)
                2'b00:   r[k] = a[k] && b[k];
                2'b01:   r[k] = a[k] || b[k];
                2'b10:   r[k] = a[k] != b[k];
                default: r[k] = a[k];
            endcase
        end
        return r;
    endfunction

    function automatic logic [W-1:0] m_res(input int id);
        logic [W-1:0] a, b;
        logic [1:0]   op;
        a = '0;
        b = '0;
        if (id == 0) begin
            a = bus.a0; b = bus.b0; op = bus.op0;
        end else if (id == 1) begin
            for (int k = 0; k < W; k++) begin
                a[W-1-k] = bus.a1[k];
                b[W-1-k] = bus.b1[k];
            end
            op = bus.op1;
        end else begin
            a[0] = bus.a2[1]; a[1] = bus.a2[2];
            b[0] = bus.b2[1]; b[1] = bus.b2[2];
            op = bus.op2;
        end
        return m_f(op, a, b);
    endfunction

    always @(negedge clk) begin
        int  win;
        int  room;
        bit  pop;
        logic [2:0] e_gnt;
        pop  = bus.res_ready && (qid.size() > 0);
        room = qid.size() - (pop ? 1 : 0);
        win  = -1;
        for (int k = 1; k <= 3; k++)
            if (win < 0 && bus.req[(mptr + k) % 3]) win = (mptr + k) % 3;
        e_gnt = (!rst && room < 2 && win >= 0) ? 3'(1 << win) : 3'b000;
        if (known) begin
            chk("gnt", 32'(bus.gnt), 32'(e_gnt));
            chk("res_valid", 32'(bus.res_valid), 32'(qid.size() > 0));
            if (qid.size() > 0) begin
                chk("res", 32'(bus.res), 32'(qres[0]));
                chk("res_id", 32'(bus.res_id), 32'(qid[0]));
            end
        end
        if (rst) begin
            qid.delete();
            qres.delete();
            mptr  = 2;
            known = 1;
        end else if (known) begin
            if (pop) begin
                void'(qid.pop_front());
                void'(qres.pop_front());
            end
            if (e_gnt != 3'b000) begin
                qid.push_back(2'(win));
                qres.push_back(m_res(win));
                mptr = win;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    logic [W-1:0] held_res;
    logic [2:0]   rr_gnt[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [1:0]   rr_id[4]  = '{2'd0, 2'd1, 2'd2, 2'd0};

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req = 3'b000; bus.res_ready = 1'b1;
        bus.op0 = 2'b00; bus.op1 = 2'b00; bus.op2 = 2'b00;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0; bus.a2 = '0; bus.b2 = '0;
        step(); step();
        neg();
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_res", 32'(bus.res), 32'd0);
        chk("rst_res_id", 32'(bus.res_id), 32'd0);

        step();
        rst = 1'b0;
        bus.req = 3'b001; bus.a0 = 4'b1100; bus.b0 = 4'b1010; bus.op0 = 2'b00;
        neg(); chk("t1_gnt", 32'(bus.gnt), 32'b001);
        step(); bus.req = 3'b000;
        neg();
        chk("t1_valid", 32'(bus.res_valid), 32'd1);
        chk("t1_res", 32'(bus.res), 32'b1000);
        chk("t1_id", 32'(bus.res_id), 32'd0);

        step();
        bus.req = 3'b010; bus.a1 = 4'b1010; bus.b1 = 4'b1100; bus.op1 = 2'b00;
        neg(); chk("t2_gnt", 32'(bus.gnt), 32'b010);
        step(); bus.req = 3'b000;
        neg();
        chk("t2_res", 32'(bus.res), 32'b1000);
        chk("t2_id", 32'(bus.res_id), 32'd1);

        step();
        bus.req = 3'b100; bus.a2 = 2'b10; bus.b2 = 2'b01; bus.op2 = 2'b10;
        step(); bus.req = 3'b000;
        neg(); chk("t3_xor", 32'(bus.res), 32'b0011);
        step(); bus.req = 3'b100; bus.op2 = 2'b00;
        step(); bus.req = 3'b000;
        neg(); chk("t3_and", 32'(bus.res), 32'b0000);
        step(); bus.req = 3'b100; bus.op2 = 2'b11;
        step(); bus.req = 3'b000;
        neg(); chk("t3_pass", 32'(bus.res), 32'b0010);
        chk("t3_id", 32'(bus.res_id), 32'd2);

        step();
        bus.req = 3'b111; bus.op0 = 2'b01; bus.op1 = 2'b10; bus.op2 = 2'b00;
        bus.a0 = 4'b0101; bus.b0 = 4'b0011; bus.a1 = 4'b0110; bus.b1 = 4'b1111;
        bus.a2 = 2'b11; bus.b2 = 2'b01;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) bus.req = 3'b000;
            neg();
            if (k < 4) chk("rr_gnt", 32'(bus.gnt), 32'(rr_gnt[k]));
            if (k > 0) chk("rr_id", 32'(bus.res_id), 32'(rr_id[k-1]));
            step();
        end
        bus.req = 3'b100;
        step(); bus.req = 3'b000;
        step();

        bus.req = 3'b011; bus.res_ready = 1'b0;
        bus.a0 = 4'b1001; bus.b0 = 4'b1111; bus.op0 = 2'b00;
        neg(); chk("bp_gnt0", 32'(bus.gnt), 32'b001);
        step();
        neg(); chk("bp_gnt1", 32'(bus.gnt), 32'b010);
        chk("bp_id0", 32'(bus.res_id), 32'd0);
        held_res = bus.res;
        step();
        neg(); chk("bp_gnt2", 32'(bus.gnt), 32'b000);
        chk("bp_hold", 32'(bus.res), 32'(held_res));
        chk("bp_hold_val", 32'(bus.res), 32'b1001);
        step(); bus.res_ready = 1'b1;
        neg(); chk("bp_out0", 32'(bus.res_id), 32'd0);
        chk("bp_gnt3", 32'(bus.gnt), 32'b001);
        step();
        neg(); chk("bp_out1", 32'(bus.res_id), 32'd1);

        step(); bus.req = 3'b111; bus.res_ready = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        neg(); chk("rs_gnt", 32'(bus.gnt), 32'b000);
        step(); rst = 1'b0;
        neg();
        chk("rs_valid", 32'(bus.res_valid), 32'd0);
        chk("rs_first_gnt", 32'(bus.gnt), 32'b001);
        step(); bus.res_ready = 1'b1; bus.req = 3'b000;
        step(); step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bitop_rr_arbiter.md
# bitop_rr_arbiter

Shares one W-bit bitwise logic unit (AND/OR/XOR/pass) between three requesters whose operand vectors use different declared ranges: descending [W-1:0], ascending [0:W-1], and narrow offset [2:1]. It arbitrates round-robin, accepts one operation per cycle through a two-stage pipeline (operand register, then result register), and presents results on a valid/ready output port tagged with the requester id. It sits in front of the shared logic unit and sequences every access to it.

## Interface
- W, default 4: logic unit width; legal values W >= 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  3  per-requester request; bit i belongs to requester i.
- op0, op1, op2  in  2  operation per requester: 00 AND, 01 OR, 10 XOR, 11 pass A.
- a0, b0  in  [W-1:0]  requester 0 operands.
- a1, b1  in  [0:W-1]  requester 1 operands.
- a2, b2  in  [2:1]  requester 2 operands.
- gnt  out  3  one-hot grant, combinational; operands are captured at the edge that ends the cycle in which gnt is high.
- res  out  [W-1:0]  registered result.
- res_id  out  2  registered requester id of res (0, 1 or 2).
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts res this cycle.

## Operation
- Operand alignment:
  - Requester 1 operands map by position. The leftmost bit a1[0] aligns with a0[W-1], and no bit reversal occurs.
  - Requester 2 operands are zero-extended on the left: {(W-2)'b0, a2}.
- Result: res = f(op, A, B), computed bitwise over W bits. Pass A returns A unchanged.
- Pipeline state: S1 (s1_v, op, A, B, id) and S2 (res_valid, res, res_id).
- Advance rules:
  - S2 loads from S1 when s1_v && (!res_valid || res_ready). A load sets res_valid=1.
  - If S2 accepts (res_valid && res_ready) and S1 is empty, res_valid clears.
  - S1 accepts a new operation when !s1_v or S1 advances this cycle. Otherwise s1_v clears when S1 advances.
- Arbitration:
  - The pointer ptr holds the last winner.
  - Search order is ptr+1, ptr+2, ptr+3, taken mod 3.
  - gnt is the first requester in that order with req high, and is asserted only when S1 can accept and rst=0. Otherwise gnt=000.
  - On a grant, ptr becomes the winner.
- Requester rule: hold req and operands stable until gnt is seen. Dropping req before gnt is legal and withdraws the request.
- Reset values: s1_v=0, res_valid=0, res=0, res_id=0, ptr=2 (requester 0 wins first), gnt=000 while rst=1.

## Timing
- If gnt is high in cycle C, res_valid is high in cycle C+1 when S2 is free. Latency is 1 edge from capture to result; otherwise res_valid waits for S2 to drain.
- Throughput: one grant per cycle while res_ready=1.
- Back-pressure: with res_valid=1 and res_ready=0, res and res_id stay stable. S1 fills once, and gnt stays 000 until S2 drains. Results leave in grant order; none are dropped or duplicated.
- Simultaneous accept and load: when S2 is accepted and S1 holds data on the same edge, S2 takes S1 data and res_valid stays 1.
- Reset mid-operation: at the rst edge, all in-flight operations are discarded. res_valid=0 on the next cycle, and the first grant after release follows ptr=2.

## Test plan
- Requester 0 alone, W=4, a0=4'b1100, b0=4'b1010, op0=00:
  - gnt=001 in cycle C.
  - Next cycle: res_valid=1, res=4'b1000, res_id=0.
- Requester 1 alone, a1=4'b1010, b1=4'b1100 (ascending range), op1=00: res=4'b1000, with the result in res[3] (positional mapping, not reversed).
- Requester 2 alone:
  - a2=2'b10, b2=2'b01, op2=10 gives res=4'b0011.
  - op2=00 against a zero-extended operand gives res=4'b0000.
  - op2=11 with a2=2'b10 gives res=4'b0010.
- All three req held high, res_ready=1: gnt sequence is 001, 010, 100, 001 on consecutive cycles, and res_id streams 0, 1, 2, 0 one cycle later.
- Back-pressure: req=011 with res_ready=0 for 3 cycles:
  - Two grants (001, then 010), then gnt=000.
  - res stays at requester 0's value.
  - After res_ready=1, results arrive as id 0, then 1, then the next grant resumes.
- Reset: assert rst for one cycle while res_valid=1 and s1_v=1, with req=111:
  - Next cycle: res_valid=0 and gnt=000.
  - After release, the first gnt is 001.
